// File: rtl/sprite_renderer.sv
// Sprite renderer: latches the sprite position once per frame, hit-tests the beam
// coordinate, addresses an external synchronous ROM and emits keyed colour 3 cycles later.
module sprite_renderer #(
    parameter int unsigned SPR_W      = 32,
    parameter int unsigned SPR_H      = 16,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned ADDR_W     = 9,
    parameter logic [23:0] KEY        = 24'hFF00FF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic              is_playing,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              flip_h,
    input  logic              flip_v,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              sprite_on,
    output logic [7:0]        spr_R,
    output logic [7:0]        spr_G,
    output logic [7:0]        spr_B
);

    localparam int unsigned CW = 11;
    localparam logic [CW-1:0] SPAN_X = CW'(SPR_W << SCALE_LOG2);
    localparam logic [CW-1:0] SPAN_Y = CW'(SPR_H << SCALE_LOG2);
    localparam logic [CW-1:0] MAX_SX = CW'(SPR_W - 1);
    localparam logic [CW-1:0] MAX_SY = CW'(SPR_H - 1);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

    state_t state_q, state_d;
    logic fs_meta_q, fs_meta_d, fs_sync_q, fs_sync_d, fs_prev_q, fs_prev_d;
    logic [9:0] lat_x_q, lat_x_d, lat_y_q, lat_y_d;
    logic lat_fh_q, lat_fh_d, lat_fv_q, lat_fv_d;
    logic hit1_q, hit1_d, hit2_q, hit2_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic sprite_on_q, sprite_on_d;
    logic [23:0] rgb_q, rgb_d;

    logic frame_start_c;
    logic in_x_c, in_y_c;
    logic [CW-1:0] beam_x_c, beam_y_c, org_x_c, org_y_c;
    logic [CW-1:0] sx_c, sy_c;

    assign frame_start_c = fs_sync_q & ~fs_prev_q;

    // Next-state, position latch, hit test and output pipeline
    always_comb begin
        state_d     = state_q;
        fs_meta_d   = frame_clk;
        fs_sync_d   = fs_meta_q;
        fs_prev_d   = fs_sync_q;
        lat_x_d     = lat_x_q;
        lat_y_d     = lat_y_q;
        lat_fh_d    = lat_fh_q;
        lat_fv_d    = lat_fv_q;
        hit1_d      = 1'b0;
        hit2_d      = hit1_q & is_playing;
        rom_addr_d  = rom_addr_q;
        sprite_on_d = 1'b0;
        rgb_d       = 24'h0;

        case (state_q)
            IDLE: begin
                if (is_playing) state_d = ARMED;
            end
            ARMED, ACTIVE: begin
                if (!is_playing) begin
                    state_d = IDLE;
                end else if (frame_start_c) begin
                    state_d  = ACTIVE;
                    lat_x_d  = pos_x;
                    lat_y_d  = pos_y;
                    lat_fh_d = flip_h;
                    lat_fv_d = flip_v;
                end
            end
            default: state_d = IDLE;
        endcase

        // 11-bit compare so a sprite near 1023 cannot wrap back to column 0
        beam_x_c = {1'b0, DrawX};
        beam_y_c = {1'b0, DrawY};
        org_x_c  = {1'b0, lat_x_q};
        org_y_c  = {1'b0, lat_y_q};
        in_x_c   = (beam_x_c >= org_x_c) && (beam_x_c < (org_x_c + SPAN_X));
        in_y_c   = (beam_y_c >= org_y_c) && (beam_y_c < (org_y_c + SPAN_Y));

        sx_c = (beam_x_c - org_x_c) >> SCALE_LOG2;
        sy_c = (beam_y_c - org_y_c) >> SCALE_LOG2;
        if (lat_fh_q) sx_c = MAX_SX - sx_c;
        if (lat_fv_q) sy_c = MAX_SY - sy_c;

        if ((state_q == ACTIVE) && is_playing && in_x_c && in_y_c) begin
            hit1_d     = 1'b1;
            rom_addr_d = ADDR_W'(sy_c) * ADDR_W'(SPR_W) + ADDR_W'(sx_c);
        end

        if (hit2_q && is_playing && (rom_data != KEY)) begin
            sprite_on_d = 1'b1;
            rgb_d       = rom_data;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            fs_meta_q   <= 1'b0;
            fs_sync_q   <= 1'b0;
            fs_prev_q   <= 1'b0;
            lat_x_q     <= 10'd0;
            lat_y_q     <= 10'd0;
            lat_fh_q    <= 1'b0;
            lat_fv_q    <= 1'b0;
            hit1_q      <= 1'b0;
            hit2_q      <= 1'b0;
            rom_addr_q  <= '0;
            sprite_on_q <= 1'b0;
            rgb_q       <= 24'h0;
        end else begin
            state_q     <= state_d;
            fs_meta_q   <= fs_meta_d;
            fs_sync_q   <= fs_sync_d;
            fs_prev_q   <= fs_prev_d;
            lat_x_q     <= lat_x_d;
            lat_y_q     <= lat_y_d;
            lat_fh_q    <= lat_fh_d;
            lat_fv_q    <= lat_fv_d;
            hit1_q      <= hit1_d;
            hit2_q      <= hit2_d;
            rom_addr_q  <= rom_addr_d;
            sprite_on_q <= sprite_on_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign sprite_on = sprite_on_q;
    assign spr_R     = rgb_q[23:16];
    assign spr_G     = rgb_q[15:8];
    assign spr_B     = rgb_q[7:0];

endmodule

// File: doc/sprite_renderer.md
SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 Parameter SPR_W, default 32: sprite width in source pixels (power of 2, 4..64).
REQ-002 Parameter SPR_H, default 16: sprite height in source pixels (1..64).
REQ-003 Parameter SCALE_LOG2, default 0: on-screen magnification 2^SCALE_LOG2 (0..2).
REQ-004 Parameter ADDR_W, default 9: ROM address width, SHALL satisfy 2^ADDR_W >= SPR_W*SPR_H.
REQ-005 Parameter KEY, default 24'hFF00FF: transparent colour value.
REQ-006 Clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 Reset  in  1  asynchronous, active-high reset.
REQ-008 frame_clk  in  1  vertical-sync level, sampled in the Clk domain; its rising edge marks frame start.
REQ-009 is_playing  in  1  game-active enable.
REQ-010 DrawX, DrawY  in  10 each  current beam coordinate, presented every Clk cycle.
REQ-011 pos_x, pos_y  in  10 each  requested sprite top-left corner.
REQ-012 flip_h, flip_v  in  1 each  requested horizontal/vertical mirror.
REQ-013 rom_addr  out  ADDR_W  registered read address to the external synchronous sprite ROM.
REQ-014 rom_data  in  24  {R,G,B}; valid one Clk cycle after rom_addr.
REQ-015 sprite_on  out  1  registered: current pipeline pixel is opaque sprite.
REQ-016 spr_R, spr_G, spr_B  out  8 each  registered colour; 0 whenever sprite_on is 0.

Function
REQ-017 frame_clk SHALL pass a 2-flop synchroniser; frame_start = one-cycle pulse on synchronised 0->1 transition.
REQ-018 States: IDLE, ARMED, ACTIVE.
- IDLE -> ARMED when is_playing=1.
- ARMED -> ACTIVE on frame_start.
- ACTIVE -> ACTIVE on frame_start.
- ARMED or ACTIVE -> IDLE when is_playing=0; takes priority over frame_start.
REQ-019 On each frame_start in ARMED or ACTIVE, pos_x, pos_y, flip_h and flip_v SHALL be latched; latched values SHALL be constant for the rest of the frame.
REQ-020 Hit test in ACTIVE only, 11-bit unsigned arithmetic, no wrap:
- lat_x <= DrawX < lat_x + SPR_W*2^SCALE_LOG2
- lat_y <= DrawY < lat_y + SPR_H*2^SCALE_LOG2
REQ-021 Source coordinates:
- sx = (DrawX-lat_x)>>SCALE_LOG2; sy = (DrawY-lat_y)>>SCALE_LOG2.
- flip_h replaces sx with SPR_W-1-sx; flip_v replaces sy with SPR_H-1-sy.
REQ-022 rom_addr = sy*SPR_W + sx, registered at edge E1 after DrawX/DrawY are presented; rom_addr holds its previous value on a miss.
REQ-023 Hit flag SHALL be pipelined alongside the address; sprite_on and spr_R/G/B SHALL register at E3 (latency 3 Clk cycles from DrawX/DrawY), with no bubbles.
REQ-024 Opaque pixel: sprite_on=1 and colour=rom_data only when the delayed hit is 1 and rom_data != KEY.
REQ-025 Transparent pixel (rom_data == KEY): sprite_on=0, colour 0.
REQ-026 Coordinates beyond 639/479 SHALL produce no special behaviour; sprites overlapping the screen edge are clipped by the beam range.
REQ-027 In IDLE or ARMED, the hit flag SHALL be forced to 0.
REQ-028 On the cycle is_playing falls, all in-flight hit flags SHALL be cleared; sprite_on=0 from the next edge.

Reset
REQ-029 Reset=1 SHALL asynchronously force:
- state to IDLE
- synchroniser flops, latched position/flip and pipeline hit flags to 0
- rom_addr, sprite_on and spr_R/G/B to 0
REQ-030 Reset asserted mid-frame SHALL abort drawing; after release, drawing SHALL resume only after is_playing=1 and a fresh frame_start.

Verification
REQ-031 Defaults, pos=(100,50), no flip, is_playing=1, one frame_start; DrawX=100, DrawY=50 -> rom_addr=0 after 1 cycle; sprite_on=1 with rom_data colour after 3 cycles.
REQ-032 Same setup, DrawX=131, DrawY=65 -> rom_addr=511; DrawX=132 -> sprite_on=0.
REQ-033 flip_h=1 and flip_v=1, DrawX=100, DrawY=50 -> rom_addr=511; SCALE_LOG2=1 with DrawX=101 -> sx=0, and hit extends to DrawX=163.
REQ-034 ROM returns 24'hFF00FF at a hit -> sprite_on=0, RGB=0; pos_x changed mid-frame -> no effect until next frame_start.
REQ-035 is_playing dropped during a hit run -> sprite_on=0 from the next edge; Reset pulse mid-frame -> all outputs 0 immediately, no drawing until is_playing=1 and a new frame_start.
